// File: rtl/bf_pkg.sv
// Shared beamforming package: FSM state encoding, width helpers and a
// saturation check reusable by the other beamforming blocks.
package bf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_dir_t;

    // Widest value the saturation check can classify.
    localparam int unsigned SAT_W = 64;

    // Accumulator width: exact product, channel growth and transmit growth.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned ww,
                                              input int unsigned nch, input int unsigned mtx);
        return dw + ww + $clog2(nch) + $clog2(mtx);
    endfunction

    // Output width after the weight scale has been shifted back out.
    function automatic int unsigned out_width(input int unsigned dw, input int unsigned nch,
                                              input int unsigned mtx);
        return dw + $clog2(nch) + $clog2(mtx);
    endfunction

    // Reports whether x overflows a w-bit signed range, and in which direction.
    function automatic sat_dir_t sat_check(input logic signed [SAT_W-1:0] x, input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        lo = -hi - SAT_W'(1);
        sat_check = SAT_NONE;
        if (x > hi) begin
            sat_check = SAT_POS;
        end else if (x < lo) begin
            sat_check = SAT_NEG;
        end
    endfunction

endpackage

// File: rtl/summ_sa_apod_if.sv
// Beat/result bus of the apodised summer.
//   master: drives start_sum, num_tx, sum_en, delayed_samples, weights, out_ready
//   slave : drives sum_result, valid, sat, busy, drop
interface summ_sa_apod_if #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned LANES        = 4,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned MAX_TX       = 4
);
    localparam int unsigned OUT_WIDTH = bf_pkg::out_width(DATA_WIDTH, NUM_CHANNELS, MAX_TX);
    localparam int unsigned TX_W      = $clog2(MAX_TX + 1);

    logic                            start_sum;
    logic [TX_W-1:0]                 num_tx;
    logic                            sum_en;
    logic [LANES*DATA_WIDTH-1:0]     delayed_samples;
    logic [LANES*WEIGHT_WIDTH-1:0]   weights;
    logic                            out_ready;
    logic [OUT_WIDTH-1:0]            sum_result;
    logic                            valid;
    logic                            sat;
    logic                            busy;
    logic                            drop;

    modport master (
        output start_sum, num_tx, sum_en, delayed_samples, weights, out_ready,
        input  sum_result, valid, sat, busy, drop
    );

    modport slave (
        input  start_sum, num_tx, sum_en, delayed_samples, weights, out_ready,
        output sum_result, valid, sat, busy, drop
    );
endinterface

// File: rtl/apod_lane_mac.sv
// Per-lane apodisation multipliers (stage 1) and registered lane adder tree (stage 2).
//   clk, reset : clock, synchronous active-low reset
//   flush      : discards everything in flight
//   in_valid   : samples/weights are an accepted beat
//   out_valid  : lane_sum holds the weighted sum of one beat
module apod_lane_mac #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned LANES        = 4
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      flush,
    input  logic                                                      in_valid,
    input  logic [LANES*DATA_WIDTH-1:0]                               samples,
    input  logic [LANES*WEIGHT_WIDTH-1:0]                             weights,
    output logic                                                      out_valid,
    output logic signed [DATA_WIDTH+WEIGHT_WIDTH+$clog2(LANES)-1:0]   lane_sum
);
    localparam int unsigned PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int unsigned EXT_W  = PROD_W + 1;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

    logic signed [EXT_W-1:0]  s_ext  [LANES];
    logic signed [EXT_W-1:0]  w_ext  [LANES];
    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     prod_vld_q;
    logic signed [SUM_W-1:0]  sum_c;

    // Signed sample times unsigned weight; the zero-extended weight keeps the product exact.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            s_ext[i]  = EXT_W'($signed(samples[i*DATA_WIDTH +: DATA_WIDTH]));
            w_ext[i]  = EXT_W'({1'b0, weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]});
            prod_c[i] = PROD_W'(s_ext[i] * w_ext[i]);
        end
    end

    // Lane adder tree.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum_c = sum_c + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prod_vld_q <= 1'b0;
            out_valid  <= 1'b0;
            lane_sum   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            prod_vld_q <= in_valid && !flush;
            out_valid  <= prod_vld_q && !flush;
            if (in_valid) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    prod_q[i] <= prod_c[i];
                end
            end
            if (prod_vld_q) begin
                lane_sum <= sum_c;
            end
        end
    end
endmodule

// File: rtl/summ_sa_apod.sv
// Apodised multi-lane, multi-transmit synthetic-aperture summer.
//   clk, reset : clock, synchronous active-low reset
//   bus        : beats in (start_sum/num_tx/sum_en/delayed_samples/weights),
//                result out (sum_result/valid/sat, out_ready), status (busy/drop)
module summ_sa_apod
    import bf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned LANES        = 4,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned MAX_TX       = 4
) (
    input  logic               clk,
    input  logic               reset,
    summ_sa_apod_if.slave      bus
);
    localparam int unsigned SUM_W     = DATA_WIDTH + WEIGHT_WIDTH + $clog2(LANES);
    localparam int unsigned ACC_W     = acc_width(DATA_WIDTH, WEIGHT_WIDTH, NUM_CHANNELS, MAX_TX);
    localparam int unsigned OUT_WIDTH = out_width(DATA_WIDTH, NUM_CHANNELS, MAX_TX);
    localparam int unsigned TX_W      = $clog2(MAX_TX + 1);
    localparam int unsigned BEATS     = NUM_CHANNELS / LANES;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SHIFT     = WEIGHT_WIDTH - 1;
    localparam logic [BEAT_W-1:0]    BEAT_LAST  = BEAT_W'(BEATS - 1);
    localparam logic [TX_W-1:0]      TX_MAX     = TX_W'(MAX_TX);
    // DRAIN covers the product, lane-sum and accumulate stages behind the last beat.
    localparam logic [1:0]           DRAIN_LAST = 2'd2;
    localparam logic [OUT_WIDTH-1:0] OUT_MAX    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN    = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    state_t                  state_q, state_nxt;
    logic [BEAT_W-1:0]       beat_q;
    logic [TX_W-1:0]         tx_q, tx_target_q, tx_target_c;
    logic [1:0]              drain_q;
    logic signed [ACC_W-1:0] acc_q, acc_shift_c;
    logic                    mac_valid;
    logic signed [SUM_W-1:0] mac_sum;
    sat_dir_t                sat_dir_c;
    logic [OUT_WIDTH-1:0]    result_c, result_q;
    logic                    valid_q, sat_q, busy_q, drop_q;
    logic                    last_beat_c, accept_c, clear_c, load_out_c, consume_c, drop_set_c;

    // Beat that completes the latched transmit count.
    assign last_beat_c = (state_q == ST_ACCUM) && bus.sum_en && !bus.start_sum &&
                         (beat_q == BEAT_LAST) && (tx_q == tx_target_q - TX_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next state.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start_sum) state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                if (bus.start_sum)     state_nxt = ST_ACCUM;
                else if (last_beat_c)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.start_sum)               state_nxt = ST_ACCUM;
                else if (drain_q == DRAIN_LAST)  state_nxt = ST_OUT;
            end
            ST_OUT:   if (bus.out_ready) state_nxt = bus.start_sum ? ST_ACCUM : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes.
    always_comb begin
        accept_c   = 1'b0;
        clear_c    = 1'b0;
        load_out_c = 1'b0;
        consume_c  = 1'b0;
        case (state_q)
            ST_IDLE:  clear_c = bus.start_sum;
            ST_ACCUM: begin
                clear_c  = bus.start_sum;
                accept_c = bus.sum_en && !bus.start_sum;
            end
            ST_DRAIN: begin
                clear_c    = bus.start_sum;
                load_out_c = !bus.start_sum && (drain_q == DRAIN_LAST);
            end
            ST_OUT: begin
                consume_c = bus.out_ready;
                clear_c   = bus.out_ready && bus.start_sum;
            end
            default: ;
        endcase
        drop_set_c = bus.sum_en && !accept_c && !clear_c;
    end

    // num_tx of 0 means one transmit; anything above MAX_TX clamps.
    always_comb begin
        tx_target_c = bus.num_tx;
        if (bus.num_tx == '0)        tx_target_c = TX_W'(1);
        else if (bus.num_tx > TX_MAX) tx_target_c = TX_MAX;
    end

    apod_lane_mac #(
        .DATA_WIDTH   (DATA_WIDTH),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .LANES        (LANES)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear_c),
        .in_valid  (accept_c),
        .samples   (bus.delayed_samples),
        .weights   (bus.weights),
        .out_valid (mac_valid),
        .lane_sum  (mac_sum)
    );

    // Remove the Q1.(W-1) weight scale (floor), then clamp to the output range.
    assign acc_shift_c = acc_q >>> SHIFT;
    always_comb begin
        sat_dir_c = sat_check(SAT_W'(acc_shift_c), OUT_WIDTH);
        result_c  = OUT_WIDTH'(acc_shift_c);
        case (sat_dir_c)
            SAT_POS: result_c = OUT_MAX;
            SAT_NEG: result_c = OUT_MIN;
            default: ;
        endcase
    end

    // Counters, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_q      <= '0;
            tx_q        <= '0;
            tx_target_q <= '0;
            drain_q     <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            if (clear_c) begin
                beat_q      <= '0;
                tx_q        <= '0;
                tx_target_q <= tx_target_c;
            end else if (accept_c) begin
                if (beat_q == BEAT_LAST) begin
                    beat_q <= '0;
                    tx_q   <= tx_q + TX_W'(1);
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
            drain_q <= (state_q == ST_DRAIN) ? drain_q + 2'd1 : 2'd0;
            if (clear_c)        acc_q <= '0;
            else if (mac_valid) acc_q <= acc_q + ACC_W'(mac_sum);
            if (clear_c)         drop_q <= 1'b0;
            else if (drop_set_c) drop_q <= 1'b1;
            if (load_out_c) begin
                result_q <= result_c;
                sat_q    <= (sat_dir_c != SAT_NONE);
                valid_q  <= 1'b1;
            end else if (consume_c) begin
                valid_q <= 1'b0;
                sat_q   <= 1'b0;
            end
            busy_q <= (state_nxt != ST_IDLE);
        end
    end

    assign bus.sum_result = result_q;
    assign bus.valid      = valid_q;
    assign bus.sat        = sat_q;
    assign bus.busy       = busy_q;
    assign bus.drop       = drop_q;
endmodule

// File: tb/tb_summ_sa_apod.sv
// Directed bench for summ_sa_apod with a behavioural sum model and a per-cycle result checker.
module tb_summ_sa_apod;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    summ_sa_apod_if bus ();

    summ_sa_apod dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     total = 0;
    int     bad   = 0;
    longint model_acc = 0;
    longint exp_res   = 0;
    logic   exp_sat   = 1'b0;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Expected result from the running sum: undo the 1.0 = 128 weight scale (floor), clamp to 21 bits.
    function automatic void model_predict();
        longint q;
        q = model_acc >>> 7;
        exp_sat = 1'b0;
        exp_res = q;
        if (q > 1048575) begin
            exp_res = 1048575;
            exp_sat = 1'b1;
        end else if (q < -1048576) begin
            exp_res = -1048576;
            exp_sat = 1'b1;
        end
    endfunction

    // Whenever a result is presented it must match the model, every cycle it is held.
    always @(negedge clk) begin
        if (reset && bus.valid) begin
            chk("cmp_result", longint'($signed(bus.sum_result)), exp_res);
            chk("cmp_sat", longint'(bus.sat), longint'(exp_sat));
        end
    end

    task automatic start(input int n);
        bus.num_tx    = 3'(n);
        bus.start_sum = 1'b1;
        @(posedge clk); #1;
        bus.start_sum = 1'b0;
        model_acc = 0;
    endtask

    task automatic beat(input int s0, input int s1, input int s2, input int s3,
                        input int w0, input int w1, input int w2, input int w3);
        bus.delayed_samples = {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
        bus.weights         = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
        bus.sum_en          = 1'b1;
        @(posedge clk); #1;
        bus.sum_en = 1'b0;
        model_acc += longint'(s0) * longint'(w0) + longint'(s1) * longint'(w1)
                   + longint'(s2) * longint'(w2) + longint'(s3) * longint'(w3);
    endtask

    task automatic beats(input int n, input int s, input int w);
        repeat (n) beat(s, s, s, s, w, w, w, w);
    endtask

    // A beat the DUT must discard; the model does not see it.
    task automatic stray();
        bus.delayed_samples = {4{16'sd30000}};
        bus.weights         = {4{8'd255}};
        bus.sum_en          = 1'b1;
        @(posedge clk); #1;
        bus.sum_en = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int lat, input longint lit_res, input int lit_sat);
        int k;
        model_predict();
        for (k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.valid) break;
        end
        chk({name, "_latency"}, k, lat);
        chk({name, "_result"}, longint'($signed(bus.sum_result)), lit_res);
        chk({name, "_sat"}, longint'(bus.sat), longint'(lit_sat));
    endtask

    task automatic take(input int hold);
        bus.out_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) chk("held_valid", longint'(bus.valid), 1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("consumed_valid", longint'(bus.valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.start_sum = 1'b0;
        bus.num_tx = '0;
        bus.sum_en = 1'b0;
        bus.delayed_samples = '0;
        bus.weights = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(bus.valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_drop", longint'(bus.drop), 0);
        chk("rst_result", longint'(bus.sum_result), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic sum, three cycles after the last beat.
        start(1);
        beat(237, 20, 125, 5230, 128, 128, 128, 128);
        beat(0, 0, 0, 0, 128, 128, 128, 128);
        wait_valid("basic", 3, 5612, 0);
        chk("basic_busy", longint'(bus.busy), 1);
        take(0);
        chk("idle_busy", longint'(bus.busy), 0);

        start(1);
        beats(2, -1000, 64);
        wait_valid("neg_half", 3, -4000, 0);
        take(0);

        start(2);
        beats(4, 100, 128);
        wait_valid("tx2", 3, 1600, 0);
        take(0);

        start(0);
        beats(2, 100, 128);
        wait_valid("tx0", 3, 800, 0);
        take(0);

        // Distinct per-lane weights, negative result that floors.
        start(1);
        beat(100, -200, 300, -400, 128, 64, 32, 255);
        beat(1, 2, 3, 4, 1, 2, 3, 4);
        wait_valid("lanes", 3, -722, 0);
        take(0);

        start(4);
        beats(8, 32767, 255);
        wait_valid("sat_pos", 3, 1048575, 1);
        take(0);

        // num_tx above MAX_TX clamps to four transmits.
        start(7);
        beats(8, -32768, 255);
        wait_valid("sat_neg", 3, -1048576, 1);
        take(0);

        // Abort right behind an in-flight beat.
        start(1);
        beats(1, 1000, 128);
        start(1);
        beats(2, 10, 128);
        wait_valid("abort", 3, 80, 0);
        chk("abort_drop", longint'(bus.drop), 0);
        take(0);

        // Beat during DRAIN is dropped and leaves the result alone.
        start(1);
        beats(2, 5, 128);
        stray();
        wait_valid("drain_drop", 2, 40, 0);
        chk("drain_drop_flag", longint'(bus.drop), 1);
        take(0);
        start(1);
        chk("start_clears_drop", longint'(bus.drop), 0);
        beats(2, 1, 128);
        wait_valid("after_drop", 3, 8, 0);
        take(0);
        stray();
        chk("idle_drop", longint'(bus.drop), 1);

        // Backpressure: result held for five cycles.
        start(1);
        beats(2, 100, 128);
        wait_valid("hold", 3, 800, 0);
        take(5);

        // Consume and restart in the same cycle.
        start(1);
        beats(2, 7, 128);
        wait_valid("b2b_a", 3, 56, 0);
        bus.num_tx = 3'd1;
        bus.out_ready = 1'b1;
        bus.start_sum = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.start_sum = 1'b0;
        model_acc = 0;
        chk("b2b_valid", longint'(bus.valid), 0);
        chk("b2b_busy", longint'(bus.busy), 1);
        beats(2, 3, 128);
        wait_valid("b2b_b", 3, 24, 0);
        take(0);

        // Reset in the middle of accumulation.
        start(2);
        stray();
        start(2);
        beats(1, 100, 128);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", longint'(bus.valid), 0);
        chk("midrst_busy", longint'(bus.busy), 0);
        chk("midrst_drop", longint'(bus.drop), 0);
        chk("midrst_result", longint'(bus.sum_result), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        start(1);
        beats(2, 1, 128);
        wait_valid("recover", 3, 8, 0);
        take(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
